// File: rtl/arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: FSM state encodings,
// port indices, default parameter values and a counter-width helper.
package arb_pkg;

  // FSM state encoding, kept as plain constants for legacy-tool compatibility.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_DONE = 2'd2;

  // Port indices as stored in the grant register.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  // Defaults for the top-level parameters.
  localparam int DEF_MAX_STARVE = 4;
  localparam int DEF_TIMEOUT    = 255;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_prio.sv
// Winner selection for the SDRAM arbiter. Port 1 (video) has fixed priority;
// a saturating starve counter forces a port-0 (CPU) win once port 1 has won
// MAX_STARVE consecutive arbitrations while port 0 was waiting.
module arb_prio
  import arb_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic arb_en,
  output logic winner
);

  localparam int SW = cnt_width(MAX_STARVE);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = req0 && (starve_cnt == STARVE_MAX);

  // Pick port 1 whenever it asks, unless port 0 has waited long enough.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    winner = PORT_CPU;
    if (req1 && !starved) begin
      winner = PORT_VID;
    end
  end

  // Count consecutive port-1 wins taken while port 0 was also requesting.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      starve_cnt <= '0;
    end else if (!req0) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (winner == PORT_VID) begin
        if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller. Serialises one
// transaction at a time (IDLE -> BUSY -> DONE), latches read data per port and
// returns a one-cycle ack to the granted port.
// Optional: define ARB_WATCHDOG_EN to abort a BUSY transaction after TIMEOUT
// cycles without mem_ack (ack with err = 1 and all-ones read data).
module sdram_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = 27,
  parameter int DW         = 8,
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  if (MAX_STARVE < 1) begin : g_bad_max_starve
    $error("sdram_arbiter: MAX_STARVE must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sdram_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t    state;
  logic          grant;
  logic          winner;
  logic          arb_en;
  logic          timed_out;
  logic          done_evt;
  logic [DW-1:0] done_data;

  // A new transaction is accepted only from IDLE with at least one request.
  assign arb_en = (state == ST_IDLE) && (req0 || req1);

  arb_prio #(
    .MAX_STARVE(MAX_STARVE)
  ) u_prio (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .arb_en(arb_en),
    .winner(winner)
  );

  // BUSY ends on mem_ack or on watchdog expiry; mem_ack wins a tie.
  assign done_evt  = (state == ST_BUSY) && (mem_ack || timed_out);
  assign done_data = mem_ack ? mem_rdata : {DW{1'b1}};

`ifdef ARB_WATCHDOG_EN
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wd_cnt;

  // The TIMEOUT-th BUSY edge without mem_ack is the expiry edge.
  assign timed_out = (wd_cnt == TO_LAST);

  // Count BUSY cycles; restart from zero on every entry to BUSY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != ST_BUSY) begin
      wd_cnt <= '0;
    end else if (!timed_out) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Error flag of the granted port reflects how its transaction ended.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (done_evt) begin
      if (grant == PORT_VID) begin
        err1 <= !mem_ack;
      end else begin
        err0 <= !mem_ack;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign err0      = 1'b0;
  assign err1      = 1'b0;
`endif

  // Transaction FSM and datapath: launch from IDLE, complete in BUSY, one DONE gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= PORT_CPU;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_en) begin
            grant   <= winner;
            mem_req <= 1'b1;
            if (winner == PORT_VID) begin
              mem_we    <= we1;
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
            end else begin
              mem_we    <= we0;
              mem_addr  <= addr0;
              mem_wdata <= wdata0;
            end
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_evt) begin
            mem_req <= 1'b0;
            if (grant == PORT_VID) begin
              ack1   <= 1'b1;
              rdata1 <= done_data;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= done_data;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a table of single transactions plus
// hand-written contention, back-to-back, reset and (ARB_WATCHDOG_EN) timeout runs.
module tb_sdram_arbiter;

  localparam int AW         = 27;
  localparam int DW         = 8;
  localparam int MAX_STARVE = 4;
  localparam int TIMEOUT    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  always #5 clock = ~clock;

  sdram_arbiter #(
    .AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // SDRAM controller model: acks after model_delay full BUSY cycles, or never.
  int            model_delay = 0;
  logic          model_hang  = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  int            wait_cnt    = 0;

  always @(negedge clock) begin
    if (reset || !mem_req || mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      wait_cnt  = 0;
    end else if (model_hang) begin
      mem_ack = 1'b0;
    end else if (wait_cnt >= model_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = model_rdata;
    end else begin
      wait_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata;
    int            delay;
    logic          exp_port;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  // One complete transaction; called at a negedge with the arbiter idle.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
    addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
    model_delay = v.delay; model_rdata = v.rdata; model_hang = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!mem_req && n < 8);
    check($sformatf("v%0d.mem_req_latency", idx), n, 1);
    check($sformatf("v%0d.mem_we", idx), mem_we, v.exp_we);
    check($sformatf("v%0d.mem_addr", idx), mem_addr, v.exp_addr);
    check($sformatf("v%0d.mem_wdata", idx), mem_wdata, v.exp_wdata);
    n = 0;
    do begin @(negedge clock); n++; end while (!(ack0 || ack1) && n < 40);
    check($sformatf("v%0d.ack_latency", idx), n, v.delay + 1);
    check($sformatf("v%0d.ack0", idx), ack0, v.exp_port == 1'b0);
    check($sformatf("v%0d.ack1", idx), ack1, v.exp_port == 1'b1);
    check($sformatf("v%0d.mem_req_drop", idx), mem_req, 0);
    if (v.exp_port) begin
      check($sformatf("v%0d.rdata1", idx), rdata1, v.exp_rdata);
      check($sformatf("v%0d.rdata0_hold", idx), rdata0, last_rd0);
      check($sformatf("v%0d.err1", idx), err1, 0);
      last_rd1 = v.exp_rdata;
    end else begin
      check($sformatf("v%0d.rdata0", idx), rdata0, v.exp_rdata);
      check($sformatf("v%0d.rdata1_hold", idx), rdata1, last_rd1);
      check($sformatf("v%0d.err0", idx), err0, 0);
      last_rd0 = v.exp_rdata;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d.ack_pulse", idx), {ack1, ack0}, 0);
    @(negedge clock);
  endtask

  vec_t vecs[6];
  int   exp_grant[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int   n;
    logic seen;
    vec_t rv;

    // req0 req1 we0 we1 addr0 addr1 wdata0 wdata1 rdata delay | port we addr wdata rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 27'h00100, 27'h0, 8'h11, 8'h00, 8'hA5, 1,
                1'b0, 1'b0, 27'h00100, 8'h11, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 27'h0, 27'h1FFFF, 8'h00, 8'h3C, 8'h77, 0,
                1'b1, 1'b1, 27'h1FFFF, 8'h3C, 8'h77};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 27'h2AAAA, 27'h7FFFFFF, 8'h22, 8'h33, 8'h5A, 2,
                1'b1, 1'b0, 27'h7FFFFFF, 8'h33, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 27'h7FFFFFF, 27'h0, 8'hFF, 8'h00, 8'h00, 0,
                1'b0, 1'b1, 27'h7FFFFFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 27'h12345, 27'h0, 8'h44, 8'h55, 8'hC3, 3,
                1'b1, 1'b0, 27'h0, 8'h55, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 27'h0ABCD, 27'h05555, 8'h66, 8'h99, 8'h3C, 1,
                1'b1, 1'b1, 27'h05555, 8'h99, 8'h3C};

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset.mem_bus", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("reset.port_outs", {ack0, ack1, err0, err1, rdata0, rdata1}, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Contention: both ports hold req continuously.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 27'h10; addr1 = 27'h20; model_delay = 0; model_rdata = 8'h5E;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!(ack0 || ack1) && n < 20);
      check($sformatf("contend%0d.one_ack", k), ack0 ^ ack1, 1);
      check($sformatf("contend%0d.port", k), ack1, exp_grant[k]);
      if (k > 0) check($sformatf("contend%0d.spacing", k), n, 3);
    end
    req0 = 1'b0; req1 = 1'b0;
    last_rd0 = 8'h5E; last_rd1 = 8'h5E;
    repeat (2) @(negedge clock);

    // Back-to-back on port 1 with a zero-wait controller.
    req1 = 1'b1; we1 = 1'b0; addr1 = 27'h00777; model_rdata = 8'h42;
    n = 0;
    do begin @(negedge clock); n++; end while (!ack1 && n < 20);
    check("b2b.first_ack", ack1, 1);
    n = 0;
    do begin @(negedge clock); n++; end while (!mem_req && n < 10);
    check("b2b.mem_req_gap", n, 2);
    n = 0;
    do begin @(negedge clock); n++; end while (!ack1 && n < 10);
    check("b2b.second_ack_latency", n, 1);
    check("b2b.rdata1", rdata1, 8'h42);
    req1 = 1'b0;
    repeat (2) @(negedge clock);

    // Reset asserted while BUSY.
    model_hang = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 27'h00ABC;
    n = 0;
    do begin @(negedge clock); n++; end while (!mem_req && n < 8);
    check("rst.mem_req_before", mem_req, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst.mem_req_async", mem_req, 0);
    check("rst.outputs", {mem_addr, ack0, ack1, rdata0, rdata1}, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (ack0 || ack1 || mem_req) seen = 1'b1;
    end
    check("rst.no_ack_after", seen, 0);
    last_rd0 = '0; last_rd1 = '0;
    rv = '{1'b1, 1'b0, 1'b0, 1'b0, 27'h00ABC, 27'h0, 8'h00, 8'h00, 8'h81, 1,
           1'b0, 1'b0, 27'h00ABC, 8'h00, 8'h81};
    run_vec(6, rv);

`ifdef ARB_WATCHDOG_EN
    // Controller never acks: watchdog completes with an error.
    model_hang = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 27'h00300;
    n = 0;
    do begin @(negedge clock); n++; end while (!mem_req && n < 8);
    check("wd.mem_req", mem_req, 1);
    n = 0;
    do begin @(negedge clock); n++; end while (!(ack0 || ack1) && n < 60);
    check("wd.latency", n, TIMEOUT);
    check("wd.ack0", ack0, 1);
    check("wd.err0", err0, 1);
    check("wd.rdata0", rdata0, 8'hFF);
    check("wd.mem_req_drop", mem_req, 0);
    req0 = 1'b0; model_hang = 1'b0;
    repeat (2) @(negedge clock);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
